// File: rtl/exception_return_unit.sv
// Purpose: CP0 exception state (EPC, Cause, Status.EXL, exception counter) plus fetch-redirect sequencer for exception entry and eret.
// Latency: a request sampled at edge N gives PCRedirect/PCTarget during cycle N+1; CP0 reads see the new values in that same cycle.
// Backpressure: none; requests arriving during a redirect cycle are dropped, and the detector must hold off until the handler is entered.
module exception_return_unit #(
    parameter logic [31:0] VECTOR    = 32'h8000_0180,
    parameter int          CNT_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 ChooseEPC,
    input  logic                 Cause,
    input  logic [31:0]          EPC,
    input  logic                 Eret,
    input  logic [4:0]           Cp0Sel,
    input  logic                 Cp0Write,
    input  logic [31:0]          Cp0WData,
    output logic [31:0]          Cp0RData,
    output logic                 PCRedirect,
    output logic [31:0]          PCTarget,
    output logic                 RetFlush,
    output logic                 ExcLevel,
    output logic [CNT_WIDTH-1:0] ExcCount,
    output logic [31:0]          EPCReg
);

    typedef enum logic [1:0] {
        IDLE       = 2'd0,
        EXC_REDIR  = 2'd1,
        IN_HANDLER = 2'd2,
        RET_REDIR  = 2'd3
    } state_t;

    localparam logic [4:0] SEL_STATUS = 5'd12;
    localparam logic [4:0] SEL_CAUSE  = 5'd13;
    localparam logic [4:0] SEL_EPC    = 5'd14;
    localparam logic [4:0] CODE_OV    = 5'd12;
    localparam logic [4:0] CODE_RI    = 5'd10;
    localparam logic [CNT_WIDTH-1:0] CNT_ONE = {{(CNT_WIDTH-1){1'b0}}, 1'b1};
    localparam logic [CNT_WIDTH-1:0] CNT_MAX = {CNT_WIDTH{1'b1}};

    state_t     state;
    logic [4:0] exc_code;
    logic       exc_accept;
    logic       exc_capture;
    logic       ret_accept;
    logic       epc_wr;
    logic       status_wr;

    // Decide which event is taken this edge; exception beats eret, and only the first exception captures EPC/Cause
    always_comb begin
        exc_accept  = ChooseEPC && ((state == IDLE) || (state == IN_HANDLER));
        exc_capture = ChooseEPC && (state == IDLE);
        ret_accept  = Eret && !ChooseEPC && (state == IN_HANDLER);
        epc_wr      = Cp0Write && (Cp0Sel == SEL_EPC);
        status_wr   = Cp0Write && (Cp0Sel == SEL_STATUS);
    end

    // Redirect sequencer: one-cycle redirect pulses for exception entry and return
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            PCRedirect <= 1'b0;
            PCTarget   <= 32'h0;
            RetFlush   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (ChooseEPC) begin
                        PCRedirect <= 1'b1;
                        PCTarget   <= VECTOR;
                        state      <= EXC_REDIR;
                    end
                end
                EXC_REDIR: begin
                    PCRedirect <= 1'b0;
                    state      <= IN_HANDLER;
                end
                IN_HANDLER: begin
                    if (ChooseEPC) begin
                        PCRedirect <= 1'b1;
                        PCTarget   <= VECTOR;
                        state      <= EXC_REDIR;
                    end else if (Eret) begin
                        PCRedirect <= 1'b1;
                        RetFlush   <= 1'b1;
                        PCTarget   <= EPCReg;
                        state      <= RET_REDIR;
                    end
                end
                RET_REDIR: begin
                    PCRedirect <= 1'b0;
                    RetFlush   <= 1'b0;
                    state      <= IDLE;
                end
                default: begin
                    PCRedirect <= 1'b0;
                    RetFlush   <= 1'b0;
                    state      <= IDLE;
                end
            endcase
        end
    end

    // CP0 register file: exception capture overrides a same-edge mtc0 to the same register
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            EPCReg   <= 32'h0;
            exc_code <= 5'd0;
            ExcLevel <= 1'b0;
            ExcCount <= '0;
        end else begin
            if (exc_capture) begin
                EPCReg   <= EPC;
                exc_code <= Cause ? CODE_OV : CODE_RI;
            end else if (epc_wr) begin
                EPCReg <= Cp0WData;
            end

            if (exc_accept) begin
                ExcLevel <= 1'b1;
            end else if (ret_accept) begin
                ExcLevel <= 1'b0;
            end else if (status_wr) begin
                ExcLevel <= Cp0WData[1];
            end

            if (exc_accept && (ExcCount != CNT_MAX)) begin
                ExcCount <= ExcCount + CNT_ONE;
            end
        end
    end

    // Combinational mfc0 read mux; unmapped numbers read as zero
    always_comb begin
        Cp0RData = 32'h0;
        case (Cp0Sel)
            SEL_STATUS: Cp0RData = {30'h0, ExcLevel, 1'b0};
            SEL_CAUSE:  Cp0RData = {25'h0, exc_code, 2'b00};
            SEL_EPC:    Cp0RData = EPCReg;
            default:    Cp0RData = 32'h0;
        endcase
    end

endmodule

// File: tb/tb_exception_return_unit.sv
// Directed bench: table of per-cycle vectors with hand-computed results, then hand sequences
// for counter saturation (narrow counter instance) and asynchronous reset during a redirect.
module tb_exception_return_unit;

    localparam logic [31:0] V = 32'h8000_0180;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        ChooseEPC = 1'b0;
    logic        Cause = 1'b0;
    logic [31:0] EPC = 32'h0;
    logic        Eret = 1'b0;
    logic [4:0]  Cp0Sel = 5'd0;
    logic        Cp0Write = 1'b0;
    logic [31:0] Cp0WData = 32'h0;

    logic [31:0] rdata, target, epcreg;
    logic        redir, flush, exl;
    logic [7:0]  cnt;

    logic [31:0] n_rdata, n_target, n_epcreg;
    logic        n_redir, n_flush, n_exl;
    logic [1:0]  n_cnt;

    int total = 0;
    int bad   = 0;

    always #5 clk = ~clk;

    exception_return_unit dut (
        .clk(clk), .reset(reset), .ChooseEPC(ChooseEPC), .Cause(Cause), .EPC(EPC),
        .Eret(Eret), .Cp0Sel(Cp0Sel), .Cp0Write(Cp0Write), .Cp0WData(Cp0WData),
        .Cp0RData(rdata), .PCRedirect(redir), .PCTarget(target), .RetFlush(flush),
        .ExcLevel(exl), .ExcCount(cnt), .EPCReg(epcreg)
    );

    exception_return_unit #(.CNT_WIDTH(2)) dut_n (
        .clk(clk), .reset(reset), .ChooseEPC(ChooseEPC), .Cause(Cause), .EPC(EPC),
        .Eret(Eret), .Cp0Sel(Cp0Sel), .Cp0Write(Cp0Write), .Cp0WData(Cp0WData),
        .Cp0RData(n_rdata), .PCRedirect(n_redir), .PCTarget(n_target), .RetFlush(n_flush),
        .ExcLevel(n_exl), .ExcCount(n_cnt), .EPCReg(n_epcreg)
    );

    typedef struct {
        logic        choose;
        logic        cause;
        logic [31:0] epc;
        logic        eret;
        logic [4:0]  sel;
        logic        wr;
        logic [31:0] wdata;
        logic        e_redir;
        logic [31:0] e_target;
        logic        e_flush;
        logic        e_exl;
        logic [7:0]  e_cnt;
        logic [31:0] e_epcreg;
        logic [31:0] e_rdata;
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic ch, input logic ca, input logic [31:0] ep, input logic er,
                       input logic [4:0] sl, input logic w, input logic [31:0] wd,
                       input logic rd, input logic [31:0] tg, input logic fl, input logic ex,
                       input logic [7:0] cn, input logic [31:0] eg, input logic [31:0] rv);
        vec_t v;
        v.choose = ch; v.cause = ca; v.epc = ep; v.eret = er; v.sel = sl; v.wr = w; v.wdata = wd;
        v.e_redir = rd; v.e_target = tg; v.e_flush = fl; v.e_exl = ex; v.e_cnt = cn;
        v.e_epcreg = eg; v.e_rdata = rv;
        vecs.push_back(v);
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %08h expected %08h", name, act, exp);
        end
    endtask

    task automatic drive(input logic ch, input logic ca, input logic [31:0] ep, input logic er,
                         input logic [4:0] sl, input logic w, input logic [31:0] wd);
        @(negedge clk);
        ChooseEPC = ch; Cause = ca; EPC = ep; Eret = er; Cp0Sel = sl; Cp0Write = w; Cp0WData = wd;
        @(posedge clk);
        #1;
    endtask

    task automatic check_all_zero(input string tag);
        chk({tag, " redir"}, {31'h0, redir}, 32'h0);
        chk({tag, " target"}, target, 32'h0);
        chk({tag, " flush"}, {31'h0, flush}, 32'h0);
        chk({tag, " exl"}, {31'h0, exl}, 32'h0);
        chk({tag, " cnt"}, {24'h0, cnt}, 32'h0);
        chk({tag, " n_cnt"}, {30'h0, n_cnt}, 32'h0);
        chk({tag, " epcreg"}, epcreg, 32'h0);
        chk({tag, " rdata"}, rdata, 32'h0);
    endtask

    initial begin
        // ch ca epc    er sel w wdata      | rd target fl exl cnt epcreg rdata
        add(0, 0, 32'h0,   0, 13, 0, 32'h0,        0, 32'h0,   0, 0, 0, 32'h0,   32'h0);
        add(1, 1, 32'h40,  0, 14, 0, 32'h0,        1, V,       0, 1, 1, 32'h40,  32'h40);
        add(0, 0, 32'h0,   0, 13, 0, 32'h0,        0, V,       0, 1, 1, 32'h40,  32'h30);
        add(0, 0, 32'h0,   0, 12, 0, 32'h0,        0, V,       0, 1, 1, 32'h40,  32'h2);
        add(0, 0, 32'h0,   1, 12, 0, 32'h0,        1, 32'h40,  1, 0, 1, 32'h40,  32'h0);
        add(0, 0, 32'h0,   0, 12, 0, 32'h0,        0, 32'h40,  0, 0, 1, 32'h40,  32'h0);
        add(0, 0, 32'h0,   1, 13, 0, 32'h0,        0, 32'h40,  0, 0, 1, 32'h40,  32'h30);
        add(1, 1, 32'h40,  0, 13, 0, 32'h0,        1, V,       0, 1, 2, 32'h40,  32'h30);
        add(0, 0, 32'h0,   0, 13, 0, 32'h0,        0, V,       0, 1, 2, 32'h40,  32'h30);
        add(1, 0, 32'h100, 0, 13, 0, 32'h0,        1, V,       0, 1, 3, 32'h40,  32'h30);
        add(0, 0, 32'h0,   0, 14, 0, 32'h0,        0, V,       0, 1, 3, 32'h40,  32'h40);
        add(0, 0, 32'h0,   1, 14, 0, 32'h0,        1, 32'h40,  1, 0, 3, 32'h40,  32'h40);
        add(0, 0, 32'h0,   0, 14, 0, 32'h0,        0, 32'h40,  0, 0, 3, 32'h40,  32'h40);
        add(1, 0, 32'h80,  1, 14, 1, 32'h200,      1, V,       0, 1, 4, 32'h80,  32'h80);
        add(0, 0, 32'h0,   0, 13, 0, 32'h0,        0, V,       0, 1, 4, 32'h80,  32'h28);
        add(0, 0, 32'h0,   0, 12, 1, 32'h0,        0, V,       0, 0, 4, 32'h80,  32'h0);
        add(0, 0, 32'h0,   0, 14, 1, 32'h300,      0, V,       0, 0, 4, 32'h300, 32'h300);
        add(0, 0, 32'h0,   1, 14, 0, 32'h0,        1, 32'h300, 1, 0, 4, 32'h300, 32'h300);
        add(0, 0, 32'h0,   0, 5,  0, 32'h0,        0, 32'h300, 0, 0, 4, 32'h300, 32'h0);
        add(0, 0, 32'h0,   0, 13, 1, 32'hFFFFFFFF, 0, 32'h300, 0, 0, 4, 32'h300, 32'h28);
        add(0, 0, 32'h0,   0, 12, 1, 32'h2,        0, 32'h300, 0, 1, 4, 32'h300, 32'h2);
        add(0, 0, 32'h0,   1, 12, 0, 32'h0,        0, 32'h300, 0, 1, 4, 32'h300, 32'h2);
        add(0, 0, 32'h0,   0, 12, 1, 32'hFFFFFFFD, 0, 32'h300, 0, 0, 4, 32'h300, 32'h0);

        // Reset held low for 3 cycles: everything zero
        repeat (3) @(posedge clk);
        #1;
        check_all_zero("reset");
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            drive(0, 0, 32'h0, 0, 13, 0, 32'h0);
            chk($sformatf("idle%0d redir", i), {31'h0, redir}, 32'h0);
        end

        // Table-driven main sequence
        for (int i = 0; i < vecs.size(); i++) begin
            vec_t v;
            logic [7:0] ncnt;
            v = vecs[i];
            drive(v.choose, v.cause, v.epc, v.eret, v.sel, v.wr, v.wdata);
            ncnt = (v.e_cnt > 8'd3) ? 8'd3 : v.e_cnt;
            chk($sformatf("v%0d redir", i), {31'h0, redir}, {31'h0, v.e_redir});
            chk($sformatf("v%0d target", i), target, v.e_target);
            chk($sformatf("v%0d flush", i), {31'h0, flush}, {31'h0, v.e_flush});
            chk($sformatf("v%0d exl", i), {31'h0, exl}, {31'h0, v.e_exl});
            chk($sformatf("v%0d cnt", i), {24'h0, cnt}, {24'h0, v.e_cnt});
            chk($sformatf("v%0d n_cnt", i), {30'h0, n_cnt}, {24'h0, ncnt});
            chk($sformatf("v%0d epcreg", i), epcreg, v.e_epcreg);
            chk($sformatf("v%0d rdata", i), rdata, v.e_rdata);
        end

        // Counter saturation: fresh reset, 5 exception/return rounds
        @(negedge clk);
        reset = 1'b0;
        @(negedge clk);
        reset = 1'b1;
        for (int r = 0; r < 5; r++) begin
            drive(1, 1, 32'h10, 0, 13, 0, 32'h0);
            drive(0, 0, 32'h0,  0, 13, 0, 32'h0);
            drive(0, 0, 32'h0,  1, 13, 0, 32'h0);
            drive(0, 0, 32'h0,  0, 13, 0, 32'h0);
            if (r == 2) chk("sat r3 n_cnt", {30'h0, n_cnt}, 32'h3);
        end
        chk("sat n_cnt", {30'h0, n_cnt}, 32'h3);
        chk("sat cnt", {24'h0, cnt}, 32'h5);
        chk("sat n_redir", {31'h0, n_redir}, 32'h0);

        // Asynchronous reset in the middle of an exception redirect
        drive(1, 1, 32'h44, 0, 13, 0, 32'h0);
        chk("midrst pre redir", {31'h0, redir}, 32'h1);
        chk("midrst pre target", target, V);
        ChooseEPC = 1'b0;
        reset = 1'b0;
        #1;
        check_all_zero("midrst");
        chk("midrst n_redir", {31'h0, n_redir}, 32'h0);
        @(negedge clk);
        reset = 1'b1;
        for (int i = 0; i < 3; i++) begin
            drive(0, 0, 32'h0, 0, 13, 0, 32'h0);
            chk($sformatf("post%0d redir", i), {31'h0, redir}, 32'h0);
            chk($sformatf("post%0d rdata", i), rdata, 32'h0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/exception_return_unit.md
# exception_return_unit

Coprocessor-0 style exception register file and PC-redirect sequencer that consumes the exception detector's outputs (`ChooseEPC`, `Cause`, `EPC`). It latches the faulting PC and cause, sets the exception-level bit, redirects fetch to the handler vector, and, on a return-from-exception instruction, redirects fetch back to the saved EPC and clears the exception level. It sits beside the IF-stage PC mux and the ID-stage decoder.

## Interface
- `VECTOR`, 32'h8000_0180, handler entry address driven on exception redirect
- `CNT_WIDTH`, 8, width of the saturating exception counter
- `clk`  in  1  rising-edge clock
- `reset`  in  1  asynchronous, active-low; all state cleared while low
- `ChooseEPC`  in  1  exception request from the detector, level, sampled each edge
- `Cause`  in  1  1 = arithmetic overflow, 0 = undefined instruction; valid when `ChooseEPC`=1
- `EPC`  in  32  faulting PC; valid when `ChooseEPC`=1
- `Eret`  in  1  return-from-exception decoded in ID, valid one cycle
- `Cp0Sel`  in  5  register number for read/write: 12 Status, 13 Cause, 14 EPC
- `Cp0Write`  in  1  write strobe (mtc0); only Sel 12 and 14 are writable
- `Cp0WData`  in  32  write data
- `Cp0RData`  out  32  combinational read of `Cp0Sel`; 0 for unmapped numbers
- `PCRedirect`  out  1  registered; forces PC mux to `PCTarget` for one cycle
- `PCTarget`  out  32  registered redirect address
- `RetFlush`  out  1  registered; flushes IF/ID on return redirect
- `ExcLevel`  out  1  Status.EXL (bit 1 of Status)
- `ExcCount`  out  CNT_WIDTH  saturating count of accepted exceptions
- `EPCReg`  out  32  saved EPC

## Operation
- States: IDLE, EXC_REDIR, IN_HANDLER, RET_REDIR (2-bit encoding).
- IDLE: `ChooseEPC`=1 -> capture `EPCReg`<=`EPC`, Cause[6:2]<=`Cause`?5'd12:5'd10, EXL<=1, `ExcCount`+=1 (saturate at all-ones), `PCTarget`<=`VECTOR`, `PCRedirect`<=1 -> EXC_REDIR. `Eret` in IDLE is ignored (no redirect, no state change).
- EXC_REDIR: lasts exactly one cycle; `PCRedirect`<=0 -> IN_HANDLER. Requests in this cycle are ignored.
- IN_HANDLER: `ChooseEPC`=1 (nested) -> EPC/Cause not overwritten, counter still increments, redirect to `VECTOR` again, stay in IN_HANDLER via EXC_REDIR path. `Eret`=1 -> `PCTarget`<=`EPCReg`, `PCRedirect`<=1, `RetFlush`<=1, EXL<=0 -> RET_REDIR.
- RET_REDIR: one cycle; clear `PCRedirect`, `RetFlush` -> IDLE.
- `ChooseEPC` and `Eret` same edge: exception wins, `Eret` dropped.
- mtc0: Sel 14 writes `EPCReg`; Sel 12 writes EXL from bit 1 only. Exception capture on the same edge overrides the write. Writes do not change FSM state; clearing EXL by mtc0 does not leave IN_HANDLER.
- Cause register bit layout: [6:2] ExcCode, all other bits 0. Status: bit 1 EXL, others 0.

## Timing
- Reset (low): state IDLE, `EPCReg`=0, Cause=0, EXL=0, `ExcCount`=0, `PCRedirect`=0, `PCTarget`=0, `RetFlush`=0; effective immediately, asynchronously.
- Latency: request sampled at edge N -> `PCRedirect`/`PCTarget` valid during cycle N+1, deasserted at edge N+1.
- `EPCReg`, Cause, EXL visible on `Cp0RData` in the cycle after capture.
- Reset asserted mid-redirect: redirect dropped immediately; no partial state survives.
- Counter at max stays at max; no wrap.

## Test plan
- Reset low 3 cycles -> all outputs 0; release, idle 5 cycles -> `PCRedirect` never 1.
- `ChooseEPC`=1, `Cause`=1, `EPC`=0x0000_0040 one cycle -> next cycle `PCRedirect`=1, `PCTarget`=0x8000_0180; then `EPCReg`=0x40, Cause read (Sel 13)=0x30, `ExcLevel`=1, `ExcCount`=1.
- From IN_HANDLER, `Eret`=1 -> next cycle `PCRedirect`=1, `RetFlush`=1, `PCTarget`=0x40; following cycle both 0, `ExcLevel`=0, state IDLE.
- Nested: second request `Cause`=0, `EPC`=0x100 in IN_HANDLER -> redirect to 0x8000_0180, `EPCReg` stays 0x40, Cause stays 0x30, `ExcCount`=2.
- Same-edge `ChooseEPC`=1 and `Eret`=1 from IDLE -> exception taken, `PCTarget`=0x8000_0180, no `RetFlush`; mtc0 Sel 14 with data 0x200 on capture edge -> `EPCReg`=captured `EPC`.
- Counter saturation with CNT_WIDTH=2: 5 exception/return rounds -> `ExcCount`=3; `reset` pulsed low mid EXC_REDIR -> `PCRedirect` drops same cycle, all registers 0.
